// File: rtl/id_ex_stage.sv
// ID/EX pipeline register for the 5-stage RV32I core.
// Captures operands, immediate, PC and decoded control from ID. Detects
// load-use hazards against the load currently in EX and inserts a bubble
// for them, inserts a bubble on a taken branch/jump flush, and freezes on a
// downstream hold. Drives the upstream stall that freezes PC and IF/ID.
module id_ex_stage #(
  parameter int CTRL_W = 8,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              id_valid,
  input  logic [31:0]       id_pc,
  input  logic [31:0]       id_rs1Data,
  input  logic [31:0]       id_rs2Data,
  input  logic [31:0]       id_imm,
  input  logic [4:0]        id_rs1Addr,
  input  logic [4:0]        id_rs2Addr,
  input  logic [4:0]        id_rdAddr,
  input  logic              id_useRs1,
  input  logic              id_useRs2,
  input  logic              id_RegWrite,
  input  logic              id_MemRead,
  input  logic              id_MemWrite,
  input  logic [CTRL_W-1:0] id_ctrl,
  input  logic              ex_flush,
  input  logic              ex_hold,
  output logic              ex_valid,
  output logic [31:0]       ex_pc,
  output logic [31:0]       ex_rs1Data,
  output logic [31:0]       ex_rs2Data,
  output logic [31:0]       ex_imm,
  output logic [4:0]        ex_rs1Addr,
  output logic [4:0]        ex_rs2Addr,
  output logic [4:0]        ex_rdAddr,
  output logic              ex_RegWrite,
  output logic              ex_MemRead,
  output logic              ex_MemWrite,
  output logic [CTRL_W-1:0] ex_ctrl,
  output logic              stall,
  output logic [CNT_W-1:0]  bubble_cnt
);

  // Saturating increment: an all-ones count stays put.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    logic [CNT_W-1:0] one;
    one = {{(CNT_W-1){1'b0}}, 1'b1};
    return (&v) ? v : (v + one);
  endfunction

  logic              valid_q,     valid_d;
  logic [31:0]       pc_q,        pc_d;
  logic [31:0]       rs1_data_q,  rs1_data_d;
  logic [31:0]       rs2_data_q,  rs2_data_d;
  logic [31:0]       imm_q,       imm_d;
  logic [4:0]        rs1_addr_q,  rs1_addr_d;
  logic [4:0]        rs2_addr_q,  rs2_addr_d;
  logic [4:0]        rd_addr_q,   rd_addr_d;
  logic              reg_write_q, reg_write_d;
  logic              mem_read_q,  mem_read_d;
  logic              mem_write_q, mem_write_d;
  logic [CTRL_W-1:0] ctrl_q,      ctrl_d;
  logic [CNT_W-1:0]  cnt_q,       cnt_d;

  logic rs1_match;
  logic rs2_match;
  logic lu;

  // Load-use hazard: a real load in EX writing a non-zero rd that the real
  // instruction in ID reads. Store-data (rs2) dependencies count as well,
  // since there is no MEM->EX store-data forwarding path.
  always_comb begin
    rs1_match = id_useRs1 & (id_rs1Addr == rd_addr_q);
    rs2_match = id_useRs2 & (id_rs2Addr == rd_addr_q);
    lu        = valid_q & mem_read_q & (rd_addr_q != 5'd0) & id_valid &
                (rs1_match | rs2_match);
    // A flush kills the dependent instruction, so there is nothing to wait for.
    stall     = ex_hold | (lu & ~ex_flush);
  end

  // Next-state selection: hold beats flush, flush beats load-use bubble,
  // otherwise the ID instruction is loaded with its control gated by id_valid.
  always_comb begin
    valid_d     = valid_q;
    pc_d        = pc_q;
    rs1_data_d  = rs1_data_q;
    rs2_data_d  = rs2_data_q;
    imm_d       = imm_q;
    rs1_addr_d  = rs1_addr_q;
    rs2_addr_d  = rs2_addr_q;
    rd_addr_d   = rd_addr_q;
    reg_write_d = reg_write_q;
    mem_read_d  = mem_read_q;
    mem_write_d = mem_write_q;
    ctrl_d      = ctrl_q;
    cnt_d       = cnt_q;
    if (ex_hold) begin
      // keep everything; a pending flush is re-issued by EX after the hold
    end else if (ex_flush || lu) begin
      // Bubble: data/address fields are don't-care and cleared for tidiness.
      valid_d     = 1'b0;
      pc_d        = 32'd0;
      rs1_data_d  = 32'd0;
      rs2_data_d  = 32'd0;
      imm_d       = 32'd0;
      rs1_addr_d  = 5'd0;
      rs2_addr_d  = 5'd0;
      rd_addr_d   = 5'd0;
      reg_write_d = 1'b0;
      mem_read_d  = 1'b0;
      mem_write_d = 1'b0;
      ctrl_d      = '0;
      if (!ex_flush) begin
        cnt_d = sat_inc(cnt_q);
      end
    end else begin
      valid_d     = id_valid;
      pc_d        = id_pc;
      rs1_data_d  = id_rs1Data;
      rs2_data_d  = id_rs2Data;
      imm_d       = id_imm;
      rs1_addr_d  = id_rs1Addr;
      rs2_addr_d  = id_rs2Addr;
      rd_addr_d   = id_rdAddr;
      reg_write_d = id_RegWrite & id_valid;
      mem_read_d  = id_MemRead  & id_valid;
      mem_write_d = id_MemWrite & id_valid;
      ctrl_d      = id_ctrl & {CTRL_W{id_valid}};
    end
  end

  // ID/EX register; reset clears the slot to a bubble and zeroes the counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q     <= 1'b0;
      pc_q        <= 32'd0;
      rs1_data_q  <= 32'd0;
      rs2_data_q  <= 32'd0;
      imm_q       <= 32'd0;
      rs1_addr_q  <= 5'd0;
      rs2_addr_q  <= 5'd0;
      rd_addr_q   <= 5'd0;
      reg_write_q <= 1'b0;
      mem_read_q  <= 1'b0;
      mem_write_q <= 1'b0;
      ctrl_q      <= '0;
      cnt_q       <= '0;
    end else begin
      valid_q     <= valid_d;
      pc_q        <= pc_d;
      rs1_data_q  <= rs1_data_d;
      rs2_data_q  <= rs2_data_d;
      imm_q       <= imm_d;
      rs1_addr_q  <= rs1_addr_d;
      rs2_addr_q  <= rs2_addr_d;
      rd_addr_q   <= rd_addr_d;
      reg_write_q <= reg_write_d;
      mem_read_q  <= mem_read_d;
      mem_write_q <= mem_write_d;
      ctrl_q      <= ctrl_d;
      cnt_q       <= cnt_d;
    end
  end

  // Output wiring
  always_comb begin
    ex_valid    = valid_q;
    ex_pc       = pc_q;
    ex_rs1Data  = rs1_data_q;
    ex_rs2Data  = rs2_data_q;
    ex_imm      = imm_q;
    ex_rs1Addr  = rs1_addr_q;
    ex_rs2Addr  = rs2_addr_q;
    ex_rdAddr   = rd_addr_q;
    ex_RegWrite = reg_write_q;
    ex_MemRead  = mem_read_q;
    ex_MemWrite = mem_write_q;
    ex_ctrl     = ctrl_q;
    bubble_cnt  = cnt_q;
  end

endmodule

// File: tb/tb_id_ex_stage.sv
// Testbench for id_ex_stage: scoreboard of expected EX-slot contents, one
// task per scenario. A second instance with a 2-bit counter covers saturation.
module tb_id_ex_stage;

  typedef struct packed {
    logic        valid;
    logic [31:0] pc;
    logic [31:0] rs1d;
    logic [31:0] rs2d;
    logic [31:0] imm;
    logic [4:0]  rs1a;
    logic [4:0]  rs2a;
    logic [4:0]  rda;
    logic        rw;
    logic        mr;
    logic        mw;
    logic [7:0]  ctrl;
  } ex_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        id_valid, id_useRs1, id_useRs2, id_RegWrite, id_MemRead, id_MemWrite;
  logic [31:0] id_pc, id_rs1Data, id_rs2Data, id_imm;
  logic [4:0]  id_rs1Addr, id_rs2Addr, id_rdAddr;
  logic [7:0]  id_ctrl;
  logic        ex_flush, ex_hold;

  logic        ex_valid, ex_RegWrite, ex_MemRead, ex_MemWrite, stall;
  logic [31:0] ex_pc, ex_rs1Data, ex_rs2Data, ex_imm;
  logic [4:0]  ex_rs1Addr, ex_rs2Addr, ex_rdAddr;
  logic [7:0]  ex_ctrl;
  logic [15:0] bubble_cnt;

  logic        ex_valid2, ex_RegWrite2, ex_MemRead2, ex_MemWrite2, stall2;
  logic [31:0] ex_pc2, ex_rs1Data2, ex_rs2Data2, ex_imm2;
  logic [4:0]  ex_rs1Addr2, ex_rs2Addr2, ex_rdAddr2;
  logic [7:0]  ex_ctrl2;
  logic [1:0]  bubble_cnt2;

  ex_t act, act2, exp_e;
  ex_t sb[$];
  int  n_cmp = 0;
  int  n_fail = 0;
  int  exp_cnt = 0;

  assign act  = {ex_valid, ex_pc, ex_rs1Data, ex_rs2Data, ex_imm, ex_rs1Addr, ex_rs2Addr,
                 ex_rdAddr, ex_RegWrite, ex_MemRead, ex_MemWrite, ex_ctrl};
  assign act2 = {ex_valid2, ex_pc2, ex_rs1Data2, ex_rs2Data2, ex_imm2, ex_rs1Addr2, ex_rs2Addr2,
                 ex_rdAddr2, ex_RegWrite2, ex_MemRead2, ex_MemWrite2, ex_ctrl2};

  always #5 clk = ~clk;

  id_ex_stage #(.CTRL_W(8), .CNT_W(16)) dut (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_pc(id_pc), .id_rs1Data(id_rs1Data),
    .id_rs2Data(id_rs2Data), .id_imm(id_imm), .id_rs1Addr(id_rs1Addr), .id_rs2Addr(id_rs2Addr),
    .id_rdAddr(id_rdAddr), .id_useRs1(id_useRs1), .id_useRs2(id_useRs2),
    .id_RegWrite(id_RegWrite), .id_MemRead(id_MemRead), .id_MemWrite(id_MemWrite),
    .id_ctrl(id_ctrl), .ex_flush(ex_flush), .ex_hold(ex_hold), .ex_valid(ex_valid),
    .ex_pc(ex_pc), .ex_rs1Data(ex_rs1Data), .ex_rs2Data(ex_rs2Data), .ex_imm(ex_imm),
    .ex_rs1Addr(ex_rs1Addr), .ex_rs2Addr(ex_rs2Addr), .ex_rdAddr(ex_rdAddr),
    .ex_RegWrite(ex_RegWrite), .ex_MemRead(ex_MemRead), .ex_MemWrite(ex_MemWrite),
    .ex_ctrl(ex_ctrl), .stall(stall), .bubble_cnt(bubble_cnt));

  id_ex_stage #(.CTRL_W(8), .CNT_W(2)) dut2 (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_pc(id_pc), .id_rs1Data(id_rs1Data),
    .id_rs2Data(id_rs2Data), .id_imm(id_imm), .id_rs1Addr(id_rs1Addr), .id_rs2Addr(id_rs2Addr),
    .id_rdAddr(id_rdAddr), .id_useRs1(id_useRs1), .id_useRs2(id_useRs2),
    .id_RegWrite(id_RegWrite), .id_MemRead(id_MemRead), .id_MemWrite(id_MemWrite),
    .id_ctrl(id_ctrl), .ex_flush(ex_flush), .ex_hold(ex_hold), .ex_valid(ex_valid2),
    .ex_pc(ex_pc2), .ex_rs1Data(ex_rs1Data2), .ex_rs2Data(ex_rs2Data2), .ex_imm(ex_imm2),
    .ex_rs1Addr(ex_rs1Addr2), .ex_rs2Addr(ex_rs2Addr2), .ex_rdAddr(ex_rdAddr2),
    .ex_RegWrite(ex_RegWrite2), .ex_MemRead(ex_MemRead2), .ex_MemWrite(ex_MemWrite2),
    .ex_ctrl(ex_ctrl2), .stall(stall2), .bubble_cnt(bubble_cnt2));

  // Instruction with random data fields and chosen addresses/control.
  function automatic ex_t mk(logic v, logic [4:0] rd, logic [4:0] rs1, logic [4:0] rs2,
                             logic rw, logic mr, logic mw);
    ex_t r;
    r.valid = v;        r.pc = $urandom;    r.rs1d = $urandom;
    r.rs2d = $urandom;  r.imm = $urandom;   r.rs1a = rs1;
    r.rs2a = rs2;       r.rda = rd;         r.rw = rw;
    r.mr = mr;          r.mw = mw;          r.ctrl = 8'($urandom);
    return r;
  endfunction

  // What EX should hold after an instruction is loaded normally.
  function automatic ex_t loaded(ex_t i);
    ex_t r;
    r = i;
    if (!i.valid) begin
      r.rw = 1'b0; r.mr = 1'b0; r.mw = 1'b0; r.ctrl = 8'd0;
    end
    return r;
  endfunction

  task automatic drive_id(input ex_t i, input logic u1, input logic u2);
    id_valid = i.valid;    id_pc = i.pc;          id_rs1Data = i.rs1d;
    id_rs2Data = i.rs2d;   id_imm = i.imm;        id_rs1Addr = i.rs1a;
    id_rs2Addr = i.rs2a;   id_rdAddr = i.rda;     id_RegWrite = i.rw;
    id_MemRead = i.mr;     id_MemWrite = i.mw;    id_ctrl = i.ctrl;
    id_useRs1 = u1;        id_useRs2 = u2;
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    ex_t nop;
    nop = '0;
    rst = 1'b1; ex_flush = 1'b0; ex_hold = 1'b0;
    drive_id(nop, 1'b0, 1'b0);
    tick(); tick();
    n_cmp++;
    if (act !== '0 || stall !== 1'b0 || bubble_cnt !== 16'd0) begin
      $display("FAIL reset_state act=%h stall=%b cnt=%0d required all 0", act, stall, bubble_cnt);
      n_fail++;
    end
    rst = 1'b0;
    exp_cnt = 0;
    sb.push_back('0);
    tick();
    exp_e = sb.pop_front(); n_cmp++;
    if (act !== exp_e || stall !== 1'b0) begin
      $display("FAIL reset_idle act=%h stall=%b required %h stall=0", act, stall, exp_e);
      n_fail++;
    end
  endtask

  task automatic test_back_to_back;
    ex_t ins;
    for (int k = 0; k < 6; k++) begin
      ins = mk((k != 3), 5'(k + 10), 5'(k + 1), 5'(k + 2), 1'b1, 1'b0, (k == 4));
      drive_id(ins, 1'b1, 1'b1);
      #1;
      n_cmp++;
      if (stall !== 1'b0) begin
        $display("FAIL b2b_stall k=%0d act=%b required 0", k, stall); n_fail++;
      end
      sb.push_back(loaded(ins));
      tick();
      exp_e = sb.pop_front(); n_cmp++;
      if (act !== exp_e) begin
        $display("FAIL b2b_load k=%0d act=%h required %h", k, act, exp_e); n_fail++;
      end
    end
  endtask

  task automatic test_load_use;
    ex_t lw, add;
    lw  = mk(1'b1, 5'd5, 5'd1, 5'd0, 1'b1, 1'b1, 1'b0);
    add = mk(1'b1, 5'd6, 5'd5, 5'd7, 1'b1, 1'b0, 1'b0);
    drive_id(lw, 1'b1, 1'b0);
    sb.push_back(loaded(lw));
    tick();
    exp_e = sb.pop_front(); n_cmp++;
    if (act !== exp_e) begin $display("FAIL lu_lw act=%h required %h", act, exp_e); n_fail++; end
    drive_id(add, 1'b1, 1'b1);
    #1; n_cmp++;
    if (stall !== 1'b1) begin $display("FAIL lu_stall act=%b required 1", stall); n_fail++; end
    sb.push_back('0);
    tick();
    exp_cnt++;
    exp_e = sb.pop_front(); n_cmp++;
    if (act !== exp_e || bubble_cnt !== 16'(exp_cnt)) begin
      $display("FAIL lu_bubble act=%h cnt=%0d required %h cnt=%0d", act, bubble_cnt, exp_e, exp_cnt);
      n_fail++;
    end
    n_cmp++;
    if (stall !== 1'b0) begin $display("FAIL lu_release act=%b required 0", stall); n_fail++; end
    sb.push_back(loaded(add));
    tick();
    exp_e = sb.pop_front(); n_cmp++;
    if (act !== exp_e || bubble_cnt !== 16'(exp_cnt)) begin
      $display("FAIL lu_add act=%h cnt=%0d required %h cnt=%0d", act, bubble_cnt, exp_e, exp_cnt);
      n_fail++;
    end
  endtask

  task automatic test_x0;
    ex_t lw, dep;
    lw  = mk(1'b1, 5'd0, 5'd3, 5'd0, 1'b1, 1'b1, 1'b0);
    dep = mk(1'b1, 5'd8, 5'd0, 5'd0, 1'b1, 1'b0, 1'b0);
    drive_id(lw, 1'b1, 1'b0);
    sb.push_back(loaded(lw));
    tick();
    exp_e = sb.pop_front(); n_cmp++;
    if (act !== exp_e) begin $display("FAIL x0_lw act=%h required %h", act, exp_e); n_fail++; end
    drive_id(dep, 1'b1, 1'b1);
    #1; n_cmp++;
    if (stall !== 1'b0) begin $display("FAIL x0_stall act=%b required 0", stall); n_fail++; end
    sb.push_back(loaded(dep));
    tick();
    exp_e = sb.pop_front(); n_cmp++;
    if (act !== exp_e || bubble_cnt !== 16'(exp_cnt)) begin
      $display("FAIL x0_dep act=%h cnt=%0d required %h cnt=%0d", act, bubble_cnt, exp_e, exp_cnt);
      n_fail++;
    end
  endtask

  task automatic test_store_rs2;
    ex_t lw, sw;
    lw = mk(1'b1, 5'd9, 5'd4, 5'd0, 1'b1, 1'b1, 1'b0);
    sw = mk(1'b1, 5'd0, 5'd2, 5'd9, 1'b0, 1'b0, 1'b1);
    drive_id(lw, 1'b1, 1'b0);
    sb.push_back(loaded(lw));
    tick();
    exp_e = sb.pop_front(); n_cmp++;
    if (act !== exp_e) begin $display("FAIL st_lw act=%h required %h", act, exp_e); n_fail++; end
    drive_id(sw, 1'b1, 1'b1);
    #1; n_cmp++;
    if (stall !== 1'b1) begin $display("FAIL st_stall act=%b required 1", stall); n_fail++; end
    sb.push_back('0);
    tick();
    exp_cnt++;
    exp_e = sb.pop_front(); n_cmp++;
    if (act !== exp_e || bubble_cnt !== 16'(exp_cnt)) begin
      $display("FAIL st_bubble act=%h cnt=%0d required %h cnt=%0d", act, bubble_cnt, exp_e, exp_cnt);
      n_fail++;
    end
    sb.push_back(loaded(sw));
    tick();
    exp_e = sb.pop_front(); n_cmp++;
    if (act !== exp_e) begin $display("FAIL st_sw act=%h required %h", act, exp_e); n_fail++; end
  endtask

  task automatic test_flush_lu;
    ex_t lw, dep;
    lw  = mk(1'b1, 5'd5, 5'd1, 5'd0, 1'b1, 1'b1, 1'b0);
    dep = mk(1'b1, 5'd6, 5'd5, 5'd5, 1'b1, 1'b0, 1'b0);
    drive_id(lw, 1'b1, 1'b0);
    sb.push_back(loaded(lw));
    tick();
    exp_e = sb.pop_front(); n_cmp++;
    if (act !== exp_e) begin $display("FAIL fl_lw act=%h required %h", act, exp_e); n_fail++; end
    drive_id(dep, 1'b1, 1'b1);
    ex_flush = 1'b1;
    #1; n_cmp++;
    if (stall !== 1'b0) begin $display("FAIL fl_stall act=%b required 0", stall); n_fail++; end
    sb.push_back('0);
    tick();
    ex_flush = 1'b0;
    exp_e = sb.pop_front(); n_cmp++;
    if (act !== exp_e || bubble_cnt !== 16'(exp_cnt)) begin
      $display("FAIL fl_bubble act=%h cnt=%0d required %h cnt=%0d", act, bubble_cnt, exp_e, exp_cnt);
      n_fail++;
    end
    sb.push_back(loaded(dep));
    tick();
    exp_e = sb.pop_front(); n_cmp++;
    if (act !== exp_e) begin $display("FAIL fl_dep act=%h required %h", act, exp_e); n_fail++; end
  endtask

  task automatic test_hold;
    ex_t a, ins;
    a = mk(1'b1, 5'd12, 5'd13, 5'd14, 1'b1, 1'b0, 1'b1);
    drive_id(a, 1'b1, 1'b1);
    sb.push_back(loaded(a));
    tick();
    exp_e = sb.pop_front(); n_cmp++;
    if (act !== exp_e) begin $display("FAIL hold_a act=%h required %h", act, exp_e); n_fail++; end
    ex_hold = 1'b1;
    for (int k = 0; k < 3; k++) begin
      ins = mk(1'b1, 5'(k + 20), 5'(k + 1), 5'(k + 2), 1'b1, 1'b0, 1'b0);
      drive_id(ins, 1'b1, 1'b0);
      ex_flush = (k == 1);
      #1; n_cmp++;
      if (stall !== 1'b1) begin $display("FAIL hold_stall k=%0d act=%b required 1", k, stall); n_fail++; end
      sb.push_back(loaded(a));
      tick();
      exp_e = sb.pop_front(); n_cmp++;
      if (act !== exp_e) begin $display("FAIL hold_keep k=%0d act=%h required %h", k, act, exp_e); n_fail++; end
    end
    ex_hold = 1'b0; ex_flush = 1'b0;
    ins = mk(1'b1, 5'd25, 5'd26, 5'd27, 1'b1, 1'b0, 1'b0);
    drive_id(ins, 1'b1, 1'b1);
    #1; n_cmp++;
    if (stall !== 1'b0) begin $display("FAIL hold_release act=%b required 0", stall); n_fail++; end
    sb.push_back(loaded(ins));
    tick();
    exp_e = sb.pop_front(); n_cmp++;
    if (act !== exp_e) begin $display("FAIL hold_load act=%h required %h", act, exp_e); n_fail++; end
  endtask

  task automatic test_reset_mid_stall;
    ex_t lw, dep;
    lw  = mk(1'b1, 5'd7, 5'd1, 5'd0, 1'b1, 1'b1, 1'b0);
    dep = mk(1'b1, 5'd8, 5'd7, 5'd0, 1'b1, 1'b0, 1'b0);
    drive_id(lw, 1'b1, 1'b0);
    sb.push_back(loaded(lw));
    tick();
    exp_e = sb.pop_front(); n_cmp++;
    if (act !== exp_e) begin $display("FAIL rs_lw act=%h required %h", act, exp_e); n_fail++; end
    drive_id(dep, 1'b1, 1'b0);
    #1; n_cmp++;
    if (stall !== 1'b1) begin $display("FAIL rs_stall act=%b required 1", stall); n_fail++; end
    #2 rst = 1'b1;
    #1; n_cmp++;
    if (act !== '0 || stall !== 1'b0 || bubble_cnt !== 16'd0) begin
      $display("FAIL rs_async act=%h stall=%b cnt=%0d required all 0", act, stall, bubble_cnt);
      n_fail++;
    end
    tick();
    rst = 1'b0;
    exp_cnt = 0;
  endtask

  task automatic test_saturation;
    ex_t lw;
    int  c2;
    lw = mk(1'b1, 5'd5, 5'd5, 5'd0, 1'b1, 1'b1, 1'b0);
    drive_id(lw, 1'b1, 1'b0);
    sb.push_back(loaded(lw));
    tick();
    exp_e = sb.pop_front(); n_cmp++;
    if (act !== exp_e || act2 !== exp_e) begin
      $display("FAIL sat_first act=%h act2=%h required %h", act, act2, exp_e); n_fail++;
    end
    for (int k = 1; k <= 5; k++) begin
      #1; n_cmp++;
      if (stall !== 1'b1 || stall2 !== 1'b1) begin
        $display("FAIL sat_stall k=%0d act=%b/%b required 1", k, stall, stall2); n_fail++;
      end
      sb.push_back('0);
      tick();
      c2 = (k < 3) ? k : 3;
      exp_e = sb.pop_front(); n_cmp++;
      if (act !== exp_e || act2 !== exp_e || bubble_cnt !== 16'(k) || bubble_cnt2 !== 2'(c2)) begin
        $display("FAIL sat_cnt k=%0d act=%0d/%0d required %0d/%0d", k, bubble_cnt, bubble_cnt2, k, c2);
        n_fail++;
      end
      sb.push_back(loaded(lw));
      tick();
      exp_e = sb.pop_front(); n_cmp++;
      if (act !== exp_e || act2 !== exp_e) begin
        $display("FAIL sat_reload k=%0d act=%h required %h", k, act, exp_e); n_fail++;
      end
    end
  endtask

  initial begin
    test_reset();
    test_back_to_back();
    test_load_use();
    test_x0();
    test_store_rs2();
    test_flush_lu();
    test_hold();
    test_reset_mid_stall();
    test_saturation();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
